// File: rtl/frog_grid_mover_if.sv
// Button/collision inputs and sprite/status outputs of frog_grid_mover.
// master drives the buttons and watches the sprite; slave is the mover itself.
interface frog_grid_mover_if #(
    parameter int unsigned SCORE_W = 7
);
    logic               i_Frog_Up;
    logic               i_Frog_Dn;
    logic               i_Frog_Lt;
    logic               i_Frog_Rt;
    logic               i_Has_Collided;
    logic               i_Restart;
    logic [9:0]         o_Frog_X;
    logic [9:0]         o_Frog_Y;
    logic [SCORE_W-1:0] o_Score;
    logic [3:0]         o_Lives;
    logic               o_Draw_Frog;
    logic               o_Game_Over;
    logic               o_Hop_Pulse;
    logic               o_Score_Pulse;

    modport master (
        output i_Frog_Up, i_Frog_Dn, i_Frog_Lt, i_Frog_Rt, i_Has_Collided, i_Restart,
        input  o_Frog_X, o_Frog_Y, o_Score, o_Lives, o_Draw_Frog, o_Game_Over,
               o_Hop_Pulse, o_Score_Pulse
    );

    modport slave (
        input  i_Frog_Up, i_Frog_Dn, i_Frog_Lt, i_Frog_Rt, i_Has_Collided, i_Restart,
        output o_Frog_X, o_Frog_Y, o_Score, o_Lives, o_Draw_Frog, o_Game_Over,
               o_Hop_Pulse, o_Score_Pulse
    );
endinterface

// File: rtl/frog_grid_mover.sv
// Grid-movement controller for the player sprite: press/auto-repeat hops, lives, game over.
// Define FROG_WRAP_EN to make horizontal moves wrap around instead of clamping at the edges.
module frog_grid_mover #(
    parameter int unsigned TILE_SIZE      = 16,
    parameter int unsigned H_VISIBLE      = 640,
    parameter int unsigned V_VISIBLE      = 480,
    parameter int unsigned X_START        = 320,
    parameter int unsigned Y_START        = 464,
    parameter int unsigned FIRST_DELAY    = 12_500_000,
    parameter int unsigned REPEAT_DELAY   = 5_000_000,
    parameter int unsigned RESPAWN_CYCLES = 25_000_000,
    parameter int unsigned LIVES_INI      = 3,
    parameter int unsigned SCORE_W        = 7
) (
    input  logic               i_Clk,
    input  logic               i_Rst_L,
    frog_grid_mover_if.slave   frog_if
);

    localparam int unsigned MaxFr = (FIRST_DELAY > REPEAT_DELAY) ? FIRST_DELAY : REPEAT_DELAY;
    localparam int unsigned MaxDelay = (MaxFr > RESPAWN_CYCLES) ? MaxFr : RESPAWN_CYCLES;
    localparam int unsigned CntW = $clog2(MaxDelay);

    localparam logic [CntW-1:0] FirstLast   = CntW'(FIRST_DELAY - 1);
    localparam logic [CntW-1:0] RepeatLast  = CntW'(REPEAT_DELAY - 1);
    localparam logic [CntW-1:0] RespawnLast = CntW'(RESPAWN_CYCLES - 1);

    localparam logic [9:0] TileW    = 10'(TILE_SIZE);
    localparam logic [9:0] XStart   = 10'(X_START);
    localparam logic [9:0] YStart   = 10'(Y_START);
    localparam logic [9:0] XMax     = 10'(H_VISIBLE - TILE_SIZE);
    localparam logic [9:0] YMax     = 10'(V_VISIBLE - TILE_SIZE);
    localparam logic [9:0] XRtLimit = 10'(H_VISIBLE - 2 * TILE_SIZE);
    localparam logic [9:0] YDnLimit = 10'(V_VISIBLE - 2 * TILE_SIZE);
    localparam logic [9:0] YHomeRow = 10'(2 * TILE_SIZE);

    localparam logic [3:0]         LivesIni = 4'(LIVES_INI);
    localparam logic [SCORE_W-1:0] ScoreMax = '1;

    localparam logic [2:0] StIdle       = 3'd0;
    localparam logic [2:0] StHeldFirst  = 3'd1;
    localparam logic [2:0] StHeldRepeat = 3'd2;
    localparam logic [2:0] StDying      = 3'd3;
    localparam logic [2:0] StGameOver   = 3'd4;

    localparam logic [1:0] DirUp = 2'd0;
    localparam logic [1:0] DirDn = 2'd1;
    localparam logic [1:0] DirLt = 2'd2;
    localparam logic [1:0] DirRt = 2'd3;

    logic [2:0]         state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [1:0]         dir_q, dir_d;
    logic [9:0]         x_q, x_d;
    logic [9:0]         y_q, y_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [3:0]         lives_q, lives_d;
    logic               draw_q, draw_d;
    logic               game_over_q, game_over_d;
    logic               hop_q, hop_d;
    logic               score_pulse_q, score_pulse_d;

    logic       dir_valid;
    logic [1:0] dir_in;
    logic [9:0] mv_x, mv_y;
    logic       mv_hop, mv_home;
    logic       do_move;
    logic       live_d;

    // Only a single pressed button is a direction; chords are ignored.
    always_comb begin
        dir_valid = 1'b1;
        dir_in    = DirUp;
        unique case ({frog_if.i_Frog_Up, frog_if.i_Frog_Dn, frog_if.i_Frog_Lt,
                      frog_if.i_Frog_Rt})
            4'b1000: dir_in = DirUp;
            4'b0100: dir_in = DirDn;
            4'b0010: dir_in = DirLt;
            4'b0001: dir_in = DirRt;
            default: dir_valid = 1'b0;
        endcase
    end

    // Candidate move from the current position; blocked moves leave mv_hop low.
    always_comb begin
        mv_x    = x_q;
        mv_y    = y_q;
        mv_hop  = 1'b0;
        mv_home = 1'b0;
        unique case (dir_in)
            DirUp: begin
                mv_hop = 1'b1;
                if (y_q >= YHomeRow) begin
                    mv_y = y_q - TileW;
                end else begin
                    mv_x    = XStart;
                    mv_y    = YStart;
                    mv_home = 1'b1;
                end
            end
            DirDn: begin
                if (y_q <= YDnLimit) begin
                    mv_y   = y_q + TileW;
                    mv_hop = 1'b1;
                end
            end
            DirLt: begin
                if (x_q >= TileW) begin
                    mv_x   = x_q - TileW;
                    mv_hop = 1'b1;
                end
`ifdef FROG_WRAP_EN
                else begin
                    mv_x   = XMax;
                    mv_hop = 1'b1;
                end
`endif
            end
            DirRt: begin
                if (x_q <= XRtLimit) begin
                    mv_x   = x_q + TileW;
                    mv_hop = 1'b1;
                end
`ifdef FROG_WRAP_EN
                else begin
                    mv_x   = 10'd0;
                    mv_hop = 1'b1;
                end
`endif
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        dir_d         = dir_q;
        x_d           = x_q;
        y_d           = y_q;
        score_d       = score_q;
        lives_d       = lives_q;
        hop_d         = 1'b0;
        score_pulse_d = 1'b0;
        do_move       = 1'b0;

        case (state_q)
            StIdle, StHeldFirst, StHeldRepeat: begin
                if (frog_if.i_Has_Collided) begin
                    lives_d = lives_q - 4'd1;
                    cnt_d   = '0;
                    state_d = (lives_q == 4'd1) ? StGameOver : StDying;
                end else if (state_q == StIdle) begin
                    if (dir_valid) begin
                        do_move = 1'b1;
                        cnt_d   = '0;
                        dir_d   = dir_in;
                        state_d = StHeldFirst;
                    end
                end else if (!dir_valid || (dir_in != dir_q)) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else if (cnt_q == ((state_q == StHeldFirst) ? FirstLast : RepeatLast)) begin
                    do_move = 1'b1;
                    cnt_d   = '0;
                    state_d = StHeldRepeat;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDying: begin
                if (cnt_q == RespawnLast) begin
                    x_d     = XStart;
                    y_d     = YStart;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StGameOver: begin
                if (frog_if.i_Restart) begin
                    lives_d = LivesIni;
                    score_d = '0;
                    x_d     = XStart;
                    y_d     = YStart;
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase

        if (do_move) begin
            x_d   = mv_x;
            y_d   = mv_y;
            hop_d = mv_hop;
            if (mv_home) begin
                score_d       = (score_q == ScoreMax) ? score_q : score_q + 1'b1;
                score_pulse_d = 1'b1;
            end
        end

        // Status flags describe the state being entered, so they line up with x/y.
        live_d      = (state_d == StIdle) || (state_d == StHeldFirst) ||
                      (state_d == StHeldRepeat);
        draw_d      = live_d && (x_d <= XMax) && (y_d <= YMax);
        game_over_d = (state_d == StGameOver);
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            dir_q         <= DirUp;
            x_q           <= XStart;
            y_q           <= YStart;
            score_q       <= '0;
            lives_q       <= LivesIni;
            draw_q        <= 1'b0;
            game_over_q   <= 1'b0;
            hop_q         <= 1'b0;
            score_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dir_q         <= dir_d;
            x_q           <= x_d;
            y_q           <= y_d;
            score_q       <= score_d;
            lives_q       <= lives_d;
            draw_q        <= draw_d;
            game_over_q   <= game_over_d;
            hop_q         <= hop_d;
            score_pulse_q <= score_pulse_d;
        end
    end

    assign frog_if.o_Frog_X      = x_q;
    assign frog_if.o_Frog_Y      = y_q;
    assign frog_if.o_Score       = score_q;
    assign frog_if.o_Lives       = lives_q;
    assign frog_if.o_Draw_Frog   = draw_q;
    assign frog_if.o_Game_Over   = game_over_q;
    assign frog_if.o_Hop_Pulse   = hop_q;
    assign frog_if.o_Score_Pulse = score_pulse_q;

endmodule

// File: tb/tb_frog_grid_mover.sv
// Randomised bench for frog_grid_mover: a hold-length based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_frog_grid_mover;

    localparam int T  = 16;
    localparam int H  = 640;
    localparam int V  = 480;
    localparam int XS = 320;
    localparam int YS = 464;
    localparam int FD = 4;
    localparam int RD = 2;
    localparam int RS = 8;
    localparam int LI = 2;
    localparam int SW = 7;

    localparam int MIdle = 0;
    localparam int MHeld = 1;
    localparam int MDead = 2;
    localparam int MOver = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    frog_grid_mover_if #(.SCORE_W(SW)) fif ();

    frog_grid_mover #(
        .TILE_SIZE(T), .H_VISIBLE(H), .V_VISIBLE(V), .X_START(XS), .Y_START(YS),
        .FIRST_DELAY(FD), .REPEAT_DELAY(RD), .RESPAWN_CYCLES(RS), .LIVES_INI(LI),
        .SCORE_W(SW)
    ) dut (
        .i_Clk   (clk),
        .i_Rst_L (rst_n),
        .frog_if (fif.slave)
    );

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks how many edges the current direction has been held.
    int m_x, m_y, m_score, m_lives, m_mode, m_hdir, m_k, m_t;
    bit m_hop, m_sp, m_draw, m_go;

    function automatic bit hop_due(input int k);
        return (k == FD) || (k > FD && ((k - FD) % RD) == 0);
    endfunction

    task automatic model_move(input int d);
        case (d)
            3: begin
                m_hop = 1'b1;
                if (m_y >= 2 * T) m_y -= T;
                else begin
                    m_x = XS;
                    m_y = YS;
                    m_score = (m_score + 1 > 2 ** SW - 1) ? 2 ** SW - 1 : m_score + 1;
                    m_sp = 1'b1;
                end
            end
            2: if (m_y + T <= V - T) begin m_y += T; m_hop = 1'b1; end
            1: begin
                if (m_x >= T) begin m_x -= T; m_hop = 1'b1; end
`ifdef FROG_WRAP_EN
                else begin m_x = H - T; m_hop = 1'b1; end
`endif
            end
            default: begin
                if (m_x + T <= H - T) begin m_x += T; m_hop = 1'b1; end
`ifdef FROG_WRAP_EN
                else begin m_x = 0; m_hop = 1'b1; end
`endif
            end
        endcase
    endtask

    always @(posedge clk) begin
        logic [3:0] btn;
        int n;
        int d;
        btn = {fif.i_Frog_Up, fif.i_Frog_Dn, fif.i_Frog_Lt, fif.i_Frog_Rt};
        n = $countones(btn);
        d = 0;
        for (int i = 0; i < 4; i++) if (btn[i]) d = i;
        m_hop = 1'b0;
        m_sp = 1'b0;
        if (!rst_n) begin
            m_x = XS; m_y = YS; m_score = 0; m_lives = LI; m_mode = MIdle; m_k = 0; m_t = 0;
        end else begin
            case (m_mode)
                MIdle, MHeld: begin
                    if (fif.i_Has_Collided) begin
                        m_lives--;
                        m_mode = (m_lives == 0) ? MOver : MDead;
                        m_t = 0;
                    end else if (m_mode == MIdle) begin
                        if (n == 1) begin
                            model_move(d);
                            m_mode = MHeld;
                            m_hdir = d;
                            m_k = 0;
                        end
                    end else if (n != 1 || d != m_hdir) begin
                        m_mode = MIdle;
                    end else begin
                        m_k++;
                        if (hop_due(m_k)) model_move(d);
                    end
                end
                MDead: begin
                    m_t++;
                    if (m_t == RS) begin m_x = XS; m_y = YS; m_mode = MIdle; end
                end
                default: begin
                    if (fif.i_Restart) begin
                        m_lives = LI; m_score = 0; m_x = XS; m_y = YS; m_mode = MIdle;
                    end
                end
            endcase
        end
        m_draw = rst_n && (m_mode == MIdle || m_mode == MHeld) && m_x <= H - T && m_y <= V - T;
        m_go = rst_n && (m_mode == MOver);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("x", fif.o_Frog_X, m_x);
            check("y", fif.o_Frog_Y, m_y);
            check("score", fif.o_Score, m_score);
            check("lives", fif.o_Lives, m_lives);
            check("draw", fif.o_Draw_Frog, m_draw);
            check("game_over", fif.o_Game_Over, m_go);
            check("hop_pulse", fif.o_Hop_Pulse, m_hop);
            check("score_pulse", fif.o_Score_Pulse, m_sp);
        end
    end

    task automatic set_btn(input logic [3:0] b);
        {fif.i_Frog_Up, fif.i_Frog_Dn, fif.i_Frog_Lt, fif.i_Frog_Rt} = b;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic tap(input logic [3:0] b, output logic hop_seen);
        set_btn(b);
        cyc(1);
        hop_seen = fif.o_Hop_Pulse;
        set_btn(4'b0000);
        cyc(1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] mask;
        logic [3:0] cur;
        logic hs;
        int hops, lows, pulses, hold_left;
        bit reached;

        set_btn(4'b0000);
        fif.i_Has_Collided = 1'b0;
        fif.i_Restart = 1'b0;
        cyc(1);
        chk_en = 1'b1;
        cyc(2);
        check("rst_x", fif.o_Frog_X, 320);
        check("rst_y", fif.o_Frog_Y, 464);
        check("rst_lives", fif.o_Lives, 2);
        check("rst_score", fif.o_Score, 0);
        check("rst_draw", fif.o_Draw_Frog, 0);
        check("rst_go", fif.o_Game_Over, 0);

        // Hold Left 10 cycles: hops on edges 1,5,7,9.
        rst_n = 1'b1;
        set_btn(4'b0010);
        mask = '0;
        for (int c = 1; c <= 10; c++) begin
            cyc(1);
            if (c == 1) check("draw_after_release", fif.o_Draw_Frog, 1);
            mask[c-1] = fif.o_Hop_Pulse;
        end
        check("hold_hop_mask", mask, 10'b0101010001);
        check("hold_x", fif.o_Frog_X, 256);
        set_btn(4'b0000);
        cyc(1);

        // Chord: no movement.
        set_btn(4'b1010);
        hops = 0;
        repeat (5) begin cyc(1); hops += fif.o_Hop_Pulse; end
        check("chord_hops", hops, 0);
        check("chord_x", fif.o_Frog_X, 256);
        check("chord_y", fif.o_Frog_Y, 464);
        set_btn(4'b0000);
        cyc(1);

        // Walk to the left edge, then try once more.
        repeat (16) tap(4'b0010, hs);
        check("left_edge_x", fif.o_Frog_X, 0);
        tap(4'b0010, hs);
`ifdef FROG_WRAP_EN
        check("left_wrap_hop", hs, 1);
        check("left_wrap_x", fif.o_Frog_X, 624);
`else
        check("left_block_hop", hs, 0);
        check("left_block_x", fif.o_Frog_X, 0);
`endif

        // Climb to the home row and cross.
        repeat (28) tap(4'b1000, hs);
        check("home_row_y", fif.o_Frog_Y, 16);
        set_btn(4'b1000);
        cyc(1);
        check("cross_x", fif.o_Frog_X, 320);
        check("cross_y", fif.o_Frog_Y, 464);
        check("cross_score", fif.o_Score, 1);
        check("cross_score_pulse", fif.o_Score_Pulse, 1);
        check("cross_hop_pulse", fif.o_Hop_Pulse, 1);
        set_btn(4'b0000);
        cyc(1);

        // Collision on the same cycle as an Up press.
        set_btn(4'b1000);
        fif.i_Has_Collided = 1'b1;
        cyc(1);
        fif.i_Has_Collided = 1'b0;
        set_btn(4'b0000);
        check("coll_y", fif.o_Frog_Y, 464);
        check("coll_hop", fif.o_Hop_Pulse, 0);
        check("coll_lives", fif.o_Lives, 1);
        lows = fif.o_Draw_Frog ? 0 : 1;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (fif.o_Draw_Frog) break;
            lows++;
        end
        check("dying_low_cycles", lows, 8);
        check("respawn_x", fif.o_Frog_X, 320);
        check("respawn_y", fif.o_Frog_Y, 464);

        // Second collision: game over, buttons ignored, then restart.
        fif.i_Has_Collided = 1'b1;
        cyc(1);
        fif.i_Has_Collided = 1'b0;
        check("over_lives", fif.o_Lives, 0);
        check("over_flag", fif.o_Game_Over, 1);
        check("over_draw", fif.o_Draw_Frog, 0);
        set_btn(4'b0001);
        hops = 0;
        repeat (6) begin cyc(1); hops += fif.o_Hop_Pulse; end
        check("over_hops", hops, 0);
        check("over_x", fif.o_Frog_X, 320);
        set_btn(4'b0000);
        fif.i_Restart = 1'b1;
        cyc(1);
        fif.i_Restart = 1'b0;
        check("restart_lives", fif.o_Lives, 2);
        check("restart_score", fif.o_Score, 0);
        check("restart_go", fif.o_Game_Over, 0);
        check("restart_draw", fif.o_Draw_Frog, 1);

        // Hold Up until the score saturates, then one more crossing.
        set_btn(4'b1000);
        reached = 1'b0;
        for (int i = 0; i < 12000; i++) begin
            cyc(1);
            if (fif.o_Score == 7'd127) begin reached = 1'b1; break; end
        end
        check("score_reach_127", reached, 1);
        pulses = 0;
        repeat (80) begin cyc(1); pulses += fif.o_Score_Pulse; end
        check("score_sat_crossed", (pulses > 0) ? 1 : 0, 1);
        check("score_sat_value", fif.o_Score, 127);
        set_btn(4'b0000);
        cyc(1);

        // Reset in the middle of dying with a button held.
        fif.i_Has_Collided = 1'b1;
        cyc(1);
        fif.i_Has_Collided = 1'b0;
        cyc(3);
        set_btn(4'b0010);
        cyc(1);
        rst_n = 1'b0;
        cyc(1);
        check("mid_rst_x", fif.o_Frog_X, 320);
        check("mid_rst_y", fif.o_Frog_Y, 464);
        check("mid_rst_score", fif.o_Score, 0);
        check("mid_rst_lives", fif.o_Lives, 2);
        check("mid_rst_draw", fif.o_Draw_Frog, 0);
        check("mid_rst_hop", fif.o_Hop_Pulse, 0);
        rst_n = 1'b1;
        cyc(1);
        check("post_rst_draw", fif.o_Draw_Frog, 1);
        check("post_rst_x", fif.o_Frog_X, 304);
        set_btn(4'b0000);
        cyc(1);

        // Random phase, checked by the model every cycle.
        hold_left = 0;
        cur = 4'b0000;
        repeat (4000) begin
            if (hold_left == 0) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4, 5: cur = 4'b0001 << $urandom_range(0, 3);
                    6, 7: cur = 4'b0000;
                    default: cur = 4'($urandom_range(0, 15));
                endcase
                hold_left = $urandom_range(1, 12);
            end
            set_btn(cur);
            hold_left--;
            fif.i_Has_Collided = ($urandom_range(0, 79) == 0);
            fif.i_Restart = ($urandom_range(0, 15) == 0);
            rst_n = ($urandom_range(0, 599) != 0);
            cyc(1);
        end
        set_btn(4'b0000);
        fif.i_Has_Collided = 1'b0;
        fif.i_Restart = 1'b0;
        rst_n = 1'b1;
        cyc(2);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
